calc_seq_n: RTL and testbench

CALC_SEQ_N -- requirements
Module: calc_seq_n

---
 rtl/calc_seq_n.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_calc_seq_n.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_n.sv
// Sequential decimal calculator: digit entry, add/sub/shift-add multiply,
// double-dabble BCD conversion and seven-segment display drive.
module calc_seq_n #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned BITS   = 27
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [3:0]             cmd,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    output logic [DIGITS-1:0][6:0] displays,
    output logic [1:0]             status,
    output logic [2:0]             ea
);

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        ENTRY_B = 3'd1,
        CALC    = 3'd2,
        CONV    = 3'd3,
        RESULT  = 3'd4,
        ERROR   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_e;

    localparam int unsigned CW = $clog2(BITS + 1);
    localparam logic [63:0]          MAX64 = 64'd10 ** DIGITS - 64'd1;
    localparam logic [2*BITS-1:0]    MAX_W = (2*BITS)'(MAX64);
    localparam logic [BITS+3:0]      MAX_E = (BITS+4)'(MAX64);
    localparam logic [BITS:0]        MAX_S = (BITS+1)'(MAX64);
    localparam logic [CW-1:0]        LAST  = CW'(BITS - 1);
    localparam logic [6:0]           SEG_ZERO = 7'b0111111;
    localparam logic [6:0]           SEG_E    = 7'b1111001;
    localparam logic [DIGITS*7-1:0]  DISP_ZERO = {{(7*(DIGITS-1)){1'b0}}, SEG_ZERO};
    localparam logic [DIGITS*7-1:0]  DISP_ERR  = {{(7*(DIGITS-1)){1'b0}}, SEG_E};

    localparam logic [3:0] CMD_EQ  = 4'b1110;
    localparam logic [3:0] CMD_CLR = 4'b1111;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    // Digits above the most significant non-zero one are blanked; digit 0 always shows.
    function automatic logic [DIGITS*7-1:0] render(input logic [4*DIGITS-1:0] bcd);
        logic        nz;
        logic [3:0]  dig;
        int unsigned idx;
        render = '0;
        nz     = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            idx = DIGITS - 1 - k;
            dig = bcd[4*idx +: 4];
            nz  = nz | (dig != 4'd0) | (idx == 0);
            render[7*idx +: 7] = nz ? seg7(dig) : 7'b0000000;
        end
    endfunction

    function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] bcd);
        logic [3:0] nib;
        add3 = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            nib = bcd[4*i +: 4];
            add3[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endfunction

    function automatic op_e op_of(input logic [3:0] c);
        case (c)
            4'b1010: op_of = OP_ADD;
            4'b1011: op_of = OP_SUB;
            default: op_of = OP_MUL;
        endcase
    endfunction

    state_e               state_q, state_d, target_q, target_d;
    op_e                  op_q, op_d;
    logic [BITS-1:0]      a_q, a_d, b_q, b_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*BITS-1:0]    acc_q, acc_d, mcand_q, mcand_d;
    logic [BITS-1:0]      mplier_q, mplier_d;
    logic [BITS-1:0]      bin_q, bin_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic [DIGITS*7-1:0]  disp_q, disp_d;

    logic                 accept, is_digit, is_op;
    logic [BITS+3:0]      ent;
    logic [BITS:0]        sum;
    logic [2*BITS-1:0]    prod;
    logic [4*DIGITS-1:0]  adj, bcd_n;
    logic                 conv_go;
    logic [BITS-1:0]      conv_val;
    state_e               conv_tgt;

    assign cmd_ready = (state_q != CALC) && (state_q != CONV);
    assign accept    = cmd_valid && cmd_ready;
    assign is_digit  = cmd <= 4'd9;
    assign is_op     = (cmd == 4'b1010) || (cmd == 4'b1011) || (cmd == 4'b1100);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        disp_d   = disp_q;
        conv_go  = 1'b0;
        conv_val = '0;
        conv_tgt = ENTRY_A;
        ent      = (BITS+4)'((state_q == ENTRY_B) ? b_q : a_q) * (BITS+4)'(10) + (BITS+4)'(cmd);
        sum      = {1'b0, a_q} + {1'b0, b_q};
        prod     = mplier_q[0] ? acc_q + mcand_q : acc_q;
        adj      = add3(bcd_q);
        bcd_n    = {adj[4*DIGITS-2:0], bin_q[BITS-1]};

        case (state_q)
            ENTRY_A, ENTRY_B, RESULT, ERROR: begin
                if (accept) begin
                    if (cmd == CMD_CLR) begin
                        a_d     = '0;
                        b_d     = '0;
                        op_d    = OP_ADD;
                        state_d = ENTRY_A;
                        disp_d  = DISP_ZERO;
                    end else if (state_q != ERROR) begin
                        if (is_digit) begin
                            if (state_q == RESULT) begin
                                a_d      = BITS'(cmd);
                                conv_go  = 1'b1;
                                conv_val = BITS'(cmd);
                                conv_tgt = ENTRY_A;
                            end else if (ent <= MAX_E) begin
                                if (state_q == ENTRY_A) a_d = BITS'(ent);
                                else                    b_d = BITS'(ent);
                                conv_go  = 1'b1;
                                conv_val = BITS'(ent);
                                conv_tgt = state_q;
                            end
                        end else if (is_op) begin
                            op_d = op_of(cmd);
                            if (state_q != ENTRY_B) begin
                                b_d      = '0;
                                conv_go  = 1'b1;
                                conv_tgt = ENTRY_B;
                            end
                        end else if (cmd == CMD_EQ && state_q == ENTRY_B) begin
                            state_d  = CALC;
                            cnt_d    = '0;
                            acc_d    = '0;
                            mcand_d  = (2*BITS)'(a_q);
                            mplier_d = b_q;
                        end
                    end
                end
            end
            CALC: begin
                case (op_q)
                    OP_ADD: begin
                        a_d = sum[BITS-1:0];
                        if (sum > MAX_S) begin
                            state_d = ERROR;
                            disp_d  = DISP_ERR;
                        end else begin
                            conv_go  = 1'b1;
                            conv_val = sum[BITS-1:0];
                            conv_tgt = RESULT;
                        end
                    end
                    OP_SUB: begin
                        a_d = a_q - b_q;
                        if (b_q > a_q) begin
                            state_d = ERROR;
                            disp_d  = DISP_ERR;
                        end else begin
                            conv_go  = 1'b1;
                            conv_val = a_q - b_q;
                            conv_tgt = RESULT;
                        end
                    end
                    default: begin
                        // One multiplier bit per cycle; the product is final on the BITS-th cycle.
                        acc_d    = prod;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        cnt_d    = cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            a_d = prod[BITS-1:0];
                            if (prod > MAX_W) begin
                                state_d = ERROR;
                                disp_d  = DISP_ERR;
                            end else begin
                                conv_go  = 1'b1;
                                conv_val = prod[BITS-1:0];
                                conv_tgt = RESULT;
                            end
                        end
                    end
                endcase
            end
            CONV: begin
                bcd_d = bcd_n;
                bin_d = {bin_q[BITS-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = target_q;
                    disp_d  = render(bcd_n);
                end
            end
            default: state_d = ENTRY_A;
        endcase

        if (conv_go) begin
            state_d  = CONV;
            target_d = conv_tgt;
            bin_d    = conv_val;
            bcd_d    = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ENTRY_A;
            target_q <= ENTRY_A;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            disp_q   <= DISP_ZERO;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            disp_q   <= disp_d;
        end
    end

    assign ea       = state_q;
    assign displays = disp_q;

    always_comb begin
        case (state_q)
            CALC, CONV: status = 2'b01;
            RESULT:     status = 2'b10;
            ERROR:      status = 2'b11;
            default:    status = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_calc_seq_n.sv
// Randomized self-checking bench for calc_seq_n against a decimal-arithmetic
// reference model of the calculator.
module tb_calc_seq_n;

    localparam int unsigned DIGITS = 8;
    localparam int unsigned BITS   = 27;
    localparam longint      MAXV   = 64'd99999999;
    localparam int          BOUND  = 500;

    logic                   clock;
    logic                   reset;
    logic [3:0]             cmd;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [DIGITS-1:0][6:0] displays;
    logic [1:0]             status;
    logic [2:0]             ea;

    calc_seq_n #(.DIGITS(DIGITS), .BITS(BITS)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .displays  (displays),
        .status    (status),
        .ea        (ea)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 entry A, 1 entry B, 4 result, 5 error.
    longint m_a, m_b;
    int     m_op, m_mode, m_busy;
    logic [6:0] seg [10];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 10; m_mode = 0; m_busy = 0;
    endtask

    // m_busy: expected cmd_ready-low cycles after acceptance, -1 when not checked.
    task automatic model_step(input int c);
        longint v, r;
        m_busy = 0;
        if (c == 15) begin
            m_a = 0; m_b = 0; m_op = 10; m_mode = 0;
        end else if (m_mode == 5) begin
            m_busy = 0;
        end else if (c <= 9) begin
            if (m_mode == 4) begin
                m_a = c; m_mode = 0; m_busy = BITS;
            end else begin
                v = ((m_mode == 1) ? m_b : m_a) * 10 + c;
                if (v <= MAXV) begin
                    if (m_mode == 1) m_b = v; else m_a = v;
                    m_busy = BITS;
                end
            end
        end else if (c >= 10 && c <= 12) begin
            m_op = c;
            if (m_mode != 1) begin
                m_b = 0; m_mode = 1; m_busy = -1;
            end
        end else if (c == 14 && m_mode == 1) begin
            if (m_op == 10)      r = m_a + m_b;
            else if (m_op == 11) r = m_a - m_b;
            else                 r = m_a * m_b;
            if ((m_op == 11 && m_b > m_a) || r > MAXV) begin
                m_mode = 5;
                m_busy = (m_op == 12) ? BITS : 1;
            end else begin
                m_a = r; m_mode = 4;
                m_busy = (m_op == 12) ? 2 * BITS : 1 + BITS;
            end
        end
    endtask

    function automatic logic [DIGITS*7-1:0] exp_disp();
        logic [DIGITS*7-1:0] r;
        longint v;
        r = '0;
        if (m_mode == 5) begin
            r[6:0] = 7'b1111001;
        end else begin
            v = (m_mode == 1) ? m_b : m_a;
            for (int i = 0; i < DIGITS; i++) begin
                if (i == 0 || v > 0) r[7*i +: 7] = seg[v % 10];
                v = v / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_status();
        return (m_mode == 5) ? 2'b11 : (m_mode == 4) ? 2'b10 : 2'b00;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".disp"},   displays, exp_disp());
        check({tag, ".status"}, status, exp_status());
        check({tag, ".ea"},     ea, m_mode);
    endtask

    task automatic count_busy(output int busy);
        busy = 0;
        @(negedge clock);
        while (!cmd_ready && busy < BOUND) begin
            busy++;
            @(negedge clock);
        end
    endtask

    task automatic finish_cmd(input string tag);
        int busy;
        count_busy(busy);
        if (m_busy >= 0) check({tag, ".busy"}, busy, m_busy);
        else if (busy >= BOUND) check({tag, ".hang"}, busy, 0);
        check_outputs(tag);
    endtask

    task automatic send(input int c, input string tag);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < BOUND) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= BOUND) check({tag, ".ready_wait"}, guard, 0);
        cmd = 4'(c);
        cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        model_step(c);
        finish_cmd(tag);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        check("reset.ready", cmd_ready, 1);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int c;
        seg[0] = 7'b0111111; seg[1] = 7'b0000110; seg[2] = 7'b1011011;
        seg[3] = 7'b1001111; seg[4] = 7'b1100110; seg[5] = 7'b1101101;
        seg[6] = 7'b1111101; seg[7] = 7'b0000111; seg[8] = 7'b1111111;
        seg[9] = 7'b1101111;
        cmd = 4'd0; cmd_valid = 1'b0; reset = 1'b1;
        model_reset();
        #2;
        do_reset();

        // 12 + 3 = 15
        send(1, "add.d1"); send(2, "add.d2"); send(10, "add.op");
        send(3, "add.d3"); send(14, "add.eq");
        check("add.seg1", displays[1], 7'b0000110);
        check("add.seg0", displays[0], 7'b1101101);

        // 12 * 3 = 36
        send(15, "clr"); send(1, "mul.d1"); send(2, "mul.d2");
        send(12, "mul.op"); send(3, "mul.d3"); send(14, "mul.eq");

        // 3 - 5 underflows
        send(15, "clr"); send(3, "sub.d3"); send(11, "sub.op");
        send(5, "sub.d5"); send(14, "sub.eq");
        send(7, "err.ignore"); send(14, "err.eq"); send(15, "err.clr");

        // Digit overflow, then addition overflow
        for (int i = 0; i < 9; i++) send(9, "nine");
        send(13, "reserved"); send(10, "ovf.op"); send(1, "ovf.d1");
        send(14, "ovf.eq");
        send(15, "clr");

        // Digit held valid across a multiply, then accepted as a new A
        send(1, "hold.d1"); send(2, "hold.d2"); send(12, "hold.op"); send(3, "hold.d3");
        cmd = 4'd14; cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd = 4'd7;
        model_step(14);
        count_busy(busy);
        check("hold.busy", busy, m_busy);
        check_outputs("hold.36");
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        model_step(7);
        finish_cmd("hold.d7");

        // Reset mid-calculation
        send(12, "rst.op"); send(4, "rst.d4");
        cmd = 4'd14; cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        repeat (5) @(posedge clock);
        #2 reset = 1'b0;
        #1 model_reset();
        check_outputs("midrst");
        check("midrst.ready", cmd_ready, 1);
        @(negedge clock);
        reset = 1'b1;
        send(4, "resume.d4");

        for (int n = 0; n < 300; n++) begin
            c = $urandom_range(0, 99);
            if (m_mode == 5 && $urandom_range(0, 2) == 0) c = 15;
            else if (c < 55) c = $urandom_range(0, 9);
            else if (c < 70) c = 10 + $urandom_range(0, 2);
            else if (c < 85) c = 14;
            else if (c < 92) c = 13;
            else if (c < 95) c = 15;
            else             c = $urandom_range(0, 3);
            send(c, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
